// File: rtl/com_txp_pkg.sv
// com_txp_pkg: shared link definitions for the packet transmitter.
// Holds the packet type codes, PID bytes, framing bytes, the TX state
// encoding and small helpers that classify a packet type.
package com_txp_pkg;

    // Packet type codes (btype)
    localparam logic [3:0] BT_DLINK = 4'h1;
    localparam logic [3:0] BT_ACK   = 4'h2;
    localparam logic [3:0] BT_DATA0 = 4'h3;
    localparam logic [3:0] BT_DTYPE = 4'h5;
    localparam logic [3:0] BT_DTEMP = 4'h9;
    localparam logic [3:0] BT_NAK   = 4'hA;
    localparam logic [3:0] BT_DATA1 = 4'hB;
    localparam logic [3:0] BT_STL   = 4'hE;

    // PID bytes
    localparam logic [7:0] PID_ACK   = 8'h2D;
    localparam logic [7:0] PID_NAK   = 8'hA5;
    localparam logic [7:0] PID_STL   = 8'hE1;
    localparam logic [7:0] PID_DCTL  = 8'hD2;
    localparam logic [7:0] PID_DATA0 = 8'h96;
    localparam logic [7:0] PID_DATA1 = 8'h5A;

    // Framing bytes
    localparam logic [7:0] PRE_BYTE  = 8'h5A;
    localparam logic [7:0] SYNC_BYTE = 8'h0F;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WAIT,
        S_PREM,
        S_SYNC,
        S_WPID,
        S_DNUM,
        S_WORK,
        S_CRC,
        S_GAP,
        S_DONE
    } state_e;

    function automatic logic bt_legal(input logic [3:0] bt);
        case (bt)
            BT_ACK, BT_NAK, BT_STL, BT_DLINK,
            BT_DTYPE, BT_DTEMP, BT_DATA0, BT_DATA1: bt_legal = 1'b1;
            default:                                bt_legal = 1'b0;
        endcase
    endfunction

    // Types that carry a length field, payload and CRC
    function automatic logic bt_is_data(input logic [3:0] bt);
        case (bt)
            BT_DLINK, BT_DTYPE, BT_DTEMP,
            BT_DATA0, BT_DATA1: bt_is_data = 1'b1;
            default:            bt_is_data = 1'b0;
        endcase
    endfunction

    function automatic logic bt_is_crc16(input logic [3:0] bt);
        bt_is_crc16 = (bt == BT_DATA0) || (bt == BT_DATA1);
    endfunction

    function automatic logic [7:0] bt_pid(input logic [3:0] bt);
        case (bt)
            BT_ACK:                       bt_pid = PID_ACK;
            BT_NAK:                       bt_pid = PID_NAK;
            BT_STL:                       bt_pid = PID_STL;
            BT_DLINK, BT_DTYPE, BT_DTEMP: bt_pid = PID_DCTL;
            BT_DATA0:                     bt_pid = PID_DATA0;
            BT_DATA1:                     bt_pid = PID_DATA1;
            default:                      bt_pid = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/com_txp_rdgen.sv
// com_txp_rdgen: payload RAM read generator.
// On start it latches base/dlen, waits a fixed lead so that read data
// returns exactly when the transmitter enters its payload state, then
// issues dlen consecutive reads (addresses wrap modulo 2^ADDR_W).
// Ports: clk, rst (async active-low), start (packet accepted), kill (abort),
//        dlen/base (request), ram_rxa/ram_ren (RAM read port).
module com_txp_rdgen #(
    parameter int ADDR_W  = 12,
    parameter int RAM_LAT = 2,
    parameter int PLEN    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              kill,
    input  logic [ADDR_W-1:0] dlen,
    input  logic [ADDR_W-1:0] base,
    output logic [ADDR_W-1:0] ram_rxa,
    output logic              ram_ren
);

    // Payload starts PLEN+4 cycles after the start edge; the first read must
    // be visible RAM_LAT cycles earlier, and ren is itself registered.
    localparam int LEAD = PLEN + 3 - RAM_LAT;

    logic [4:0]        dly;
    logic [ADDR_W-1:0] rem;
    logic [ADDR_W-1:0] addr;
    logic              active;
    logic              ren_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dly     <= '0;
            rem     <= '0;
            addr    <= '0;
            active  <= 1'b0;
            ren_q   <= 1'b0;
            ram_rxa <= '0;
        end else if (start) begin
            dly    <= 5'(LEAD);
            rem    <= dlen;
            addr   <= base;
            active <= 1'b1;
            ren_q  <= 1'b0;
        end else if (kill) begin
            active <= 1'b0;
            ren_q  <= 1'b0;
        end else if (active && dly != 5'd0) begin
            dly   <= dly - 5'd1;
            ren_q <= 1'b0;
        end else if (active && rem != '0) begin
            ren_q   <= 1'b1;
            ram_rxa <= addr;
            addr    <= addr + ADDR_W'(1);
            rem     <= rem - ADDR_W'(1);
        end else begin
            active <= 1'b0;
            ren_q  <= 1'b0;
        end
    end

    // Abort suppresses a read already queued for this cycle.
    assign ram_ren = ren_q & ~kill;

endmodule

// File: rtl/crc16.sv
// crc16: byte-wide CRC16 accumulator (poly 0x8005, MSB first, init 0xFFFF).
// Ports: clk, rst (async active-low), clr (sync re-init), en (absorb din),
//        din[7:0], crc[15:0] (current register value).
module crc16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  din,
    output logic [15:0] crc
);

    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h8005;
            else              r = {r[14:0], 1'b0};
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)     crc <= 16'hFFFF;
        else if (clr) crc <= 16'hFFFF;
        else if (en)  crc <= crc16_byte(crc, din);
    end

endmodule

// File: rtl/crc5.sv
// crc5: byte-wide CRC5 accumulator (x^5 + x^2 + 1, MSB first, init 0x1F).
// Ports: clk, rst (async active-low), clr (sync re-init), en (absorb din),
//        din[7:0], crc[4:0] (current register value).
module crc5 (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] din,
    output logic [4:0] crc
);

    function automatic logic [4:0] crc5_byte(input logic [4:0] c, input logic [7:0] d);
        logic [4:0] r;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            if (r[4] ^ d[i]) r = {r[3:0], 1'b0} ^ 5'h05;
            else             r = {r[3:0], 1'b0};
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)     crc <= 5'h1F;
        else if (clr) crc <= 5'h1F;
        else if (en)  crc <= crc5_byte(crc, din);
    end

endmodule

// File: rtl/com_txp.sv
// com_txp: byte-serial packet transmitter.
// Frames one packet per fs/fd handshake: preamble, sync, PID, optional
// 2-byte length, RAM payload, CRC5/CRC16, then an idle gap.
// Ports: clk, rst (async active-low); fs/fd handshake; abort; btype, tx_dlen,
//        ram_addr_init (request, latched at start); ram_rxa/ram_ren/ram_rxd
//        (payload RAM); com_txd/com_txv (registered line byte); busy; err.
// Optional: define COM_TXP_STAT_EN to add pkt_cnt/abort_cnt saturating
//        packet statistics outputs.
module com_txp
    import com_txp_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int RAM_LAT = 2,
    parameter int PLEN    = 4,
    parameter int GAP_LEN = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fs,
    output logic              fd,
    input  logic              abort,
    input  logic [3:0]        btype,
    input  logic [ADDR_W-1:0] tx_dlen,
    input  logic [ADDR_W-1:0] ram_addr_init,
    output logic [ADDR_W-1:0] ram_rxa,
    output logic              ram_ren,
    input  logic [7:0]        ram_rxd,
    output logic [7:0]        com_txd,
    output logic              com_txv,
    output logic              busy,
    output logic              err
`ifdef COM_TXP_STAT_EN
    ,
    output logic [15:0]       pkt_cnt,
    output logic [15:0]       abort_cnt
`endif
);

    generate
        if (PLEN + 3 < RAM_LAT) begin : g_lat_chk
            $error("com_txp: RAM_LAT exceeds the header length PLEN+3");
        end
    endgenerate

    state_e            state, state_nxt;
    logic [ADDR_W-1:0] cnt, cnt_nxt;
    logic [3:0]        bt_q;
    logic [ADDR_W-1:0] dlen_q;
    logic [7:0]        byte_nxt;
    logic              vld_nxt;
    logic              kill;
    logic              start;
    logic              aborted_q;
    logic [4:0]        crc5_val;
    logic [15:0]       crc16_val;

    assign busy  = !(state inside {S_IDLE, S_WAIT, S_DONE});
    assign fd    = (state == S_DONE);
    assign kill  = abort && busy;
    assign start = (state == S_WAIT) && fs && bt_legal(btype);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + ADDR_W'(1);
        byte_nxt  = 8'h00;
        vld_nxt   = 1'b0;
        case (state)
            S_IDLE: begin
                state_nxt = S_WAIT;
                cnt_nxt   = '0;
            end
            S_WAIT: begin
                cnt_nxt = '0;
                if (fs) state_nxt = bt_legal(btype) ? S_PREM : S_DONE;
            end
            S_PREM: begin
                byte_nxt = PRE_BYTE;
                vld_nxt  = 1'b1;
                if (cnt == ADDR_W'(PLEN - 1)) begin
                    state_nxt = S_SYNC;
                    cnt_nxt   = '0;
                end
            end
            S_SYNC: begin
                byte_nxt  = SYNC_BYTE;
                vld_nxt   = 1'b1;
                state_nxt = S_WPID;
                cnt_nxt   = '0;
            end
            S_WPID: begin
                byte_nxt  = bt_pid(bt_q);
                vld_nxt   = 1'b1;
                state_nxt = bt_is_data(bt_q) ? S_DNUM : S_GAP;
                cnt_nxt   = '0;
            end
            S_DNUM: begin
                vld_nxt = 1'b1;
                if (cnt == '0) begin
                    byte_nxt = 8'(dlen_q >> 8);
                end else begin
                    byte_nxt  = dlen_q[7:0];
                    state_nxt = (dlen_q == '0) ? S_CRC : S_WORK;
                    cnt_nxt   = '0;
                end
            end
            S_WORK: begin
                byte_nxt = ram_rxd;
                vld_nxt  = 1'b1;
                if (cnt == dlen_q - ADDR_W'(1)) begin
                    state_nxt = S_CRC;
                    cnt_nxt   = '0;
                end
            end
            S_CRC: begin
                vld_nxt = 1'b1;
                if (!bt_is_crc16(bt_q)) begin
                    byte_nxt  = {3'b000, crc5_val};
                    state_nxt = S_GAP;
                    cnt_nxt   = '0;
                end else if (cnt == '0) begin
                    byte_nxt = crc16_val[15:8];
                end else begin
                    byte_nxt  = crc16_val[7:0];
                    state_nxt = S_GAP;
                    cnt_nxt   = '0;
                end
            end
            S_GAP: begin
                if (cnt == ADDR_W'(GAP_LEN - 1)) begin
                    state_nxt = S_DONE;
                    cnt_nxt   = '0;
                end
            end
            S_DONE: begin
                cnt_nxt = '0;
                if (!fs) state_nxt = S_WAIT;
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
        // Abort cuts the packet: no byte this cycle, then a normal gap.
        // An abort arriving inside the gap just lets the gap finish.
        if (kill) begin
            byte_nxt = 8'h00;
            vld_nxt  = 1'b0;
            if (state != S_GAP) begin
                state_nxt = S_GAP;
                cnt_nxt   = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bt_q      <= 4'h0;
            dlen_q    <= '0;
            com_txd   <= 8'h00;
            com_txv   <= 1'b0;
            err       <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            com_txd <= byte_nxt;
            com_txv <= vld_nxt;
            err     <= (state == S_WAIT) && fs && !bt_legal(btype);
            if (state == S_WAIT) begin
                aborted_q <= 1'b0;
                if (fs) begin
                    bt_q   <= btype;
                    dlen_q <= tx_dlen;
                end
            end else if (kill) begin
                aborted_q <= 1'b1;
            end
        end
    end

    com_txp_rdgen #(
        .ADDR_W  (ADDR_W),
        .RAM_LAT (RAM_LAT),
        .PLEN    (PLEN)
    ) u_rdgen (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .kill    (kill),
        .dlen    (bt_is_data(btype) ? tx_dlen : '0),
        .base    (ram_addr_init),
        .ram_rxa (ram_rxa),
        .ram_ren (ram_ren)
    );

    // CRC covers payload bytes only; re-initialised while waiting for a request.
    crc5 u_crc5 (
        .clk (clk),
        .rst (rst),
        .clr (state == S_WAIT),
        .en  ((state == S_WORK) && !kill),
        .din (ram_rxd),
        .crc (crc5_val)
    );

    crc16 u_crc16 (
        .clk (clk),
        .rst (rst),
        .clr (state == S_WAIT),
        .en  ((state == S_WORK) && !kill),
        .din (ram_rxd),
        .crc (crc16_val)
    );

`ifdef COM_TXP_STAT_EN
    logic enter_done;
    assign enter_done = (state != S_DONE) && (state_nxt == S_DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pkt_cnt   <= 16'h0000;
            abort_cnt <= 16'h0000;
        end else if (enter_done) begin
            if (aborted_q || kill) begin
                if (abort_cnt != 16'hFFFF) abort_cnt <= abort_cnt + 16'd1;
            end else begin
                if (pkt_cnt != 16'hFFFF) pkt_cnt <= pkt_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_com_txp.sv
// tb_com_txp: directed self-checking bench for com_txp.
// Three instances share all request inputs and differ only in RAM_LAT
// (2 = main, 1, 4); each has its own RAM model with matching latency.
module tb_com_txp;

    localparam int ADDR_W  = 12;
    localparam int PLEN    = 4;
    localparam int GAP_LEN = 2;

    localparam logic [3:0] T_DLINK = 4'h1;
    localparam logic [3:0] T_ACK   = 4'h2;
    localparam logic [3:0] T_DATA0 = 4'h3;
    localparam logic [3:0] T_DATA1 = 4'hB;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              fs = 1'b0;
    logic              abort = 1'b0;
    logic [3:0]        btype = 4'h0;
    logic [ADDR_W-1:0] tx_dlen = '0;
    logic [ADDR_W-1:0] ram_addr_init = '0;

    logic [ADDR_W-1:0] rxa  [3];
    logic              ren  [3];
    logic [7:0]        rxd  [3];
    logic [7:0]        txd  [3];
    logic              txv  [3];
    logic              fdo  [3];
    logic              bsy  [3];
    logic              erro [3];
`ifdef COM_TXP_STAT_EN
    logic [15:0]       pc [3];
    logic [15:0]       ac [3];
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    com_txp #(.ADDR_W(ADDR_W), .RAM_LAT(2), .PLEN(PLEN), .GAP_LEN(GAP_LEN)) u_dut (
        .clk(clk), .rst(rst), .fs(fs), .fd(fdo[0]), .abort(abort), .btype(btype),
        .tx_dlen(tx_dlen), .ram_addr_init(ram_addr_init), .ram_rxa(rxa[0]),
        .ram_ren(ren[0]), .ram_rxd(rxd[0]), .com_txd(txd[0]), .com_txv(txv[0]),
        .busy(bsy[0]), .err(erro[0])
`ifdef COM_TXP_STAT_EN
        , .pkt_cnt(pc[0]), .abort_cnt(ac[0])
`endif
    );

    com_txp #(.ADDR_W(ADDR_W), .RAM_LAT(1), .PLEN(PLEN), .GAP_LEN(GAP_LEN)) u_lat1 (
        .clk(clk), .rst(rst), .fs(fs), .fd(fdo[1]), .abort(abort), .btype(btype),
        .tx_dlen(tx_dlen), .ram_addr_init(ram_addr_init), .ram_rxa(rxa[1]),
        .ram_ren(ren[1]), .ram_rxd(rxd[1]), .com_txd(txd[1]), .com_txv(txv[1]),
        .busy(bsy[1]), .err(erro[1])
`ifdef COM_TXP_STAT_EN
        , .pkt_cnt(pc[1]), .abort_cnt(ac[1])
`endif
    );

    com_txp #(.ADDR_W(ADDR_W), .RAM_LAT(4), .PLEN(PLEN), .GAP_LEN(GAP_LEN)) u_lat4 (
        .clk(clk), .rst(rst), .fs(fs), .fd(fdo[2]), .abort(abort), .btype(btype),
        .tx_dlen(tx_dlen), .ram_addr_init(ram_addr_init), .ram_rxa(rxa[2]),
        .ram_ren(ren[2]), .ram_rxd(rxd[2]), .com_txd(txd[2]), .com_txv(txv[2]),
        .busy(bsy[2]), .err(erro[2])
`ifdef COM_TXP_STAT_EN
        , .pkt_cnt(pc[2]), .abort_cnt(ac[2])
`endif
    );

    // RAM models: data for a read issued in cycle c is visible in cycle c+LAT
    logic [7:0] mem [0:4095];
    logic [7:0] p2 [2];
    logic [7:0] p1;
    logic [7:0] p4 [4];

    always @(posedge clk) begin
        if (ren[0]) p2[0] <= mem[rxa[0]];
        p2[1] <= p2[0];
        if (ren[1]) p1 <= mem[rxa[1]];
        if (ren[2]) p4[0] <= mem[rxa[2]];
        p4[1] <= p4[0];
        p4[2] <= p4[1];
        p4[3] <= p4[2];
    end

    assign rxd[0] = p2[1];
    assign rxd[1] = p1;
    assign rxd[2] = p4[3];

    // Per-packet capture
    logic [7:0]        q0 [$];
    logic [7:0]        q1 [$];
    logic [7:0]        q2 [$];
    logic [ADDR_W-1:0] a0 [$];
    logic [ADDR_W-1:0] a1 [$];
    logic [ADDR_W-1:0] a2 [$];
    int                fd_idx;
    int                last_v;
    int                err_n;
    logic              busy_mid;

    function automatic logic [15:0] m_crc16(input logic [7:0] b [$]);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        foreach (b[k]) begin
            for (int i = 7; i >= 0; i--) begin
                fb = c[15] ^ b[k][i];
                c  = {c[14:0], 1'b0};
                if (fb) c = c ^ 16'h8005;
            end
        end
        return c;
    endfunction

    task automatic run_packet(input logic [3:0] bt, input logic [ADDR_W-1:0] dl,
                              input logic [ADDR_W-1:0] base, input int abort_at,
                              input int scramble_at);
        q0.delete(); q1.delete(); q2.delete();
        a0.delete(); a1.delete(); a2.delete();
        fd_idx = -1; last_v = -1; err_n = 0; busy_mid = 1'b0;
        @(negedge clk);
        btype = bt; tx_dlen = dl; ram_addr_init = base; fs = 1'b1;
        for (int j = 0; j < 300; j++) begin
            @(posedge clk);
            @(negedge clk);
            if (txv[0]) begin q0.push_back(txd[0]); last_v = j; end
            if (txv[1]) q1.push_back(txd[1]);
            if (txv[2]) q2.push_back(txd[2]);
            if (ren[0]) a0.push_back(rxa[0]);
            if (ren[1]) a1.push_back(rxa[1]);
            if (ren[2]) a2.push_back(rxa[2]);
            if (erro[0]) err_n++;
            if (j == 2) busy_mid = bsy[0];
            abort = (j == abort_at);
            if (j == scramble_at) begin
                btype = T_ACK; tx_dlen = 12'h009; ram_addr_init = 12'h7F0; fs = 1'b0;
            end
            if (fdo[0]) begin fd_idx = j; break; end
        end
        abort = 1'b0;
        if (fd_idx < 0) begin
            tests++; fails++;
            $display("FAIL fd_timeout got no fd want fd within 300 cycles");
        end
        fs = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        tests += 7;
        if (txd[0] !== 8'h00) begin fails++; $display("FAIL rst_txd got %02h want 00", txd[0]); end
        if (txv[0] !== 1'b0)  begin fails++; $display("FAIL rst_txv got %b want 0", txv[0]); end
        if (fdo[0] !== 1'b0)  begin fails++; $display("FAIL rst_fd got %b want 0", fdo[0]); end
        if (bsy[0] !== 1'b0)  begin fails++; $display("FAIL rst_busy got %b want 0", bsy[0]); end
        if (erro[0] !== 1'b0) begin fails++; $display("FAIL rst_err got %b want 0", erro[0]); end
        if (ren[0] !== 1'b0)  begin fails++; $display("FAIL rst_ren got %b want 0", ren[0]); end
        if (rxa[0] !== 12'h000) begin fails++; $display("FAIL rst_rxa got %03h want 000", rxa[0]); end
`ifdef COM_TXP_STAT_EN
        tests++;
        if (pc[0] !== 16'h0 || ac[0] !== 16'h0) begin
            fails++; $display("FAIL rst_stat got %04h/%04h want 0000/0000", pc[0], ac[0]);
        end
`endif
        rst = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_data0();
        logic [7:0] pay [$];
        logic [7:0] exp [$];
        logic [15:0] c;
        logic [ADDR_W-1:0] ea [$];
        mem[12'h010] = 8'h11; mem[12'h011] = 8'h22; mem[12'h012] = 8'h33; mem[12'h013] = 8'h44;
        pay = {8'h11, 8'h22, 8'h33, 8'h44};
        c = m_crc16(pay);
        exp = {8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h0F, 8'h96, 8'h00, 8'h04,
               8'h11, 8'h22, 8'h33, 8'h44, c[15:8], c[7:0]};
        ea = {12'h010, 12'h011, 12'h012, 12'h013};
        run_packet(T_DATA0, 12'd4, 12'h010, -1, -1);
        tests++;
        if (q0.size() != exp.size()) begin fails++; $display("FAIL data0_len got %0d want %0d", q0.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < q0.size(); i++) begin
            tests++;
            if (q0[i] !== exp[i]) begin fails++; $display("FAIL data0_byte%0d got %02h want %02h", i, q0[i], exp[i]); end
        end
        tests++;
        if (a0.size() != 4) begin fails++; $display("FAIL data0_ren_count got %0d want 4", a0.size()); end
        for (int i = 0; i < 4 && i < a0.size(); i++) begin
            tests++;
            if (a0[i] !== ea[i]) begin fails++; $display("FAIL data0_addr%0d got %03h want %03h", i, a0[i], ea[i]); end
        end
        tests += 4;
        if (fd_idx != last_v + GAP_LEN) begin fails++; $display("FAIL data0_gap got fd at %0d want %0d", fd_idx, last_v + GAP_LEN); end
        if (fd_idx != 16) begin fails++; $display("FAIL data0_fd_cycle got %0d want 16", fd_idx); end
        if (err_n != 0) begin fails++; $display("FAIL data0_err got %0d want 0", err_n); end
        if (busy_mid !== 1'b1) begin fails++; $display("FAIL data0_busy got %b want 1", busy_mid); end
    endtask

    task automatic test_ack();
        logic [7:0] exp [$];
        exp = {8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h0F, 8'h2D};
        run_packet(T_ACK, 12'd7, 12'h020, -1, -1);
        tests++;
        if (q0.size() != exp.size()) begin fails++; $display("FAIL ack_len got %0d want %0d", q0.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < q0.size(); i++) begin
            tests++;
            if (q0[i] !== exp[i]) begin fails++; $display("FAIL ack_byte%0d got %02h want %02h", i, q0[i], exp[i]); end
        end
        tests += 2;
        if (a0.size() != 0) begin fails++; $display("FAIL ack_ren got %0d reads want 0", a0.size()); end
        if (fd_idx != last_v + GAP_LEN) begin fails++; $display("FAIL ack_gap got fd at %0d want %0d", fd_idx, last_v + GAP_LEN); end
    endtask

    task automatic test_zero_len();
        logic [7:0] exp [$];
        exp = {8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h0F, 8'hD2, 8'h00, 8'h00, 8'h1F};
        run_packet(T_DLINK, 12'd0, 12'h030, -1, -1);
        tests++;
        if (q0.size() != exp.size()) begin fails++; $display("FAIL zlen_len got %0d want %0d", q0.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < q0.size(); i++) begin
            tests++;
            if (q0[i] !== exp[i]) begin fails++; $display("FAIL zlen_byte%0d got %02h want %02h", i, q0[i], exp[i]); end
        end
        tests++;
        if (a0.size() != 0) begin fails++; $display("FAIL zlen_ren got %0d reads want 0", a0.size()); end
    endtask

    task automatic test_wrap();
        logic [7:0] pay [$];
        logic [7:0] exp [$];
        logic [15:0] c;
        logic [ADDR_W-1:0] ea [$];
        mem[12'hFFE] = 8'hA1; mem[12'hFFF] = 8'hB2; mem[12'h000] = 8'hC3;
        pay = {8'hA1, 8'hB2, 8'hC3};
        c = m_crc16(pay);
        exp = {8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h0F, 8'h5A, 8'h00, 8'h03,
               8'hA1, 8'hB2, 8'hC3, c[15:8], c[7:0]};
        ea = {12'hFFE, 12'hFFF, 12'h000};
        run_packet(T_DATA1, 12'd3, 12'hFFE, -1, -1);
        tests += 3;
        if (q0.size() != exp.size()) begin fails++; $display("FAIL wrap_l2_len got %0d want %0d", q0.size(), exp.size()); end
        if (q1.size() != exp.size()) begin fails++; $display("FAIL wrap_l1_len got %0d want %0d", q1.size(), exp.size()); end
        if (q2.size() != exp.size()) begin fails++; $display("FAIL wrap_l4_len got %0d want %0d", q2.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            if (i < q0.size()) begin
                tests++;
                if (q0[i] !== exp[i]) begin fails++; $display("FAIL wrap_l2_byte%0d got %02h want %02h", i, q0[i], exp[i]); end
            end
            if (i < q1.size()) begin
                tests++;
                if (q1[i] !== exp[i]) begin fails++; $display("FAIL wrap_l1_byte%0d got %02h want %02h", i, q1[i], exp[i]); end
            end
            if (i < q2.size()) begin
                tests++;
                if (q2[i] !== exp[i]) begin fails++; $display("FAIL wrap_l4_byte%0d got %02h want %02h", i, q2[i], exp[i]); end
            end
        end
        tests += 3;
        if (a0.size() != 3) begin fails++; $display("FAIL wrap_l2_reads got %0d want 3", a0.size()); end
        if (a1.size() != 3) begin fails++; $display("FAIL wrap_l1_reads got %0d want 3", a1.size()); end
        if (a2.size() != 3) begin fails++; $display("FAIL wrap_l4_reads got %0d want 3", a2.size()); end
        for (int i = 0; i < 3; i++) begin
            if (i < a0.size()) begin
                tests++;
                if (a0[i] !== ea[i]) begin fails++; $display("FAIL wrap_l2_addr%0d got %03h want %03h", i, a0[i], ea[i]); end
            end
            if (i < a1.size()) begin
                tests++;
                if (a1[i] !== ea[i]) begin fails++; $display("FAIL wrap_l1_addr%0d got %03h want %03h", i, a1[i], ea[i]); end
            end
            if (i < a2.size()) begin
                tests++;
                if (a2[i] !== ea[i]) begin fails++; $display("FAIL wrap_l4_addr%0d got %03h want %03h", i, a2[i], ea[i]); end
            end
        end
    endtask

    task automatic test_abort();
        logic [7:0] exp [$];
        logic [7:0] pay [$];
        logic [15:0] c;
        mem[12'h010] = 8'h11; mem[12'h011] = 8'h22; mem[12'h012] = 8'h33; mem[12'h013] = 8'h44;
        exp = {8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h0F, 8'h96, 8'h00, 8'h04, 8'h11, 8'h22};
        // abort raised while the 2nd payload byte is on the line
        run_packet(T_DATA0, 12'd4, 12'h010, 10, -1);
        tests++;
        if (q0.size() != exp.size()) begin fails++; $display("FAIL abort_len got %0d want %0d", q0.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < q0.size(); i++) begin
            tests++;
            if (q0[i] !== exp[i]) begin fails++; $display("FAIL abort_byte%0d got %02h want %02h", i, q0[i], exp[i]); end
        end
        tests += 2;
        if (last_v != 10) begin fails++; $display("FAIL abort_txv_drop got last valid %0d want 10", last_v); end
        if (fd_idx != 13) begin fails++; $display("FAIL abort_fd_cycle got %0d want 13", fd_idx); end
        // following packet must be clean
        pay = {8'h33, 8'h44};
        c = m_crc16(pay);
        exp = {8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h0F, 8'h5A, 8'h00, 8'h02,
               8'h33, 8'h44, c[15:8], c[7:0]};
        run_packet(T_DATA1, 12'd2, 12'h012, -1, -1);
        tests++;
        if (q0.size() != exp.size()) begin fails++; $display("FAIL post_abort_len got %0d want %0d", q0.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < q0.size(); i++) begin
            tests++;
            if (q0[i] !== exp[i]) begin fails++; $display("FAIL post_abort_byte%0d got %02h want %02h", i, q0[i], exp[i]); end
        end
`ifdef COM_TXP_STAT_EN
        tests++;
        if (ac[0] !== 16'd1) begin fails++; $display("FAIL stat_abort_cnt got %0d want 1", ac[0]); end
`endif
    endtask

    task automatic test_illegal();
        run_packet(4'h7, 12'd5, 12'h040, -1, -1);
        tests += 4;
        if (err_n != 1) begin fails++; $display("FAIL illegal_err got %0d pulses want 1", err_n); end
        if (q0.size() != 0) begin fails++; $display("FAIL illegal_txv got %0d bytes want 0", q0.size()); end
        if (fd_idx != 0) begin fails++; $display("FAIL illegal_fd got %0d want 0", fd_idx); end
        if (a0.size() != 0) begin fails++; $display("FAIL illegal_ren got %0d reads want 0", a0.size()); end
    endtask

    task automatic test_latch();
        logic [7:0] pay [$];
        logic [7:0] exp [$];
        logic [15:0] c;
        mem[12'h100] = 8'h5C; mem[12'h101] = 8'hE7;
        pay = {8'h5C, 8'hE7};
        c = m_crc16(pay);
        exp = {8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h0F, 8'h96, 8'h00, 8'h02,
               8'h5C, 8'hE7, c[15:8], c[7:0]};
        // request inputs change and fs drops at cycle 3
        run_packet(T_DATA0, 12'd2, 12'h100, -1, 3);
        tests++;
        if (q0.size() != exp.size()) begin fails++; $display("FAIL latch_len got %0d want %0d", q0.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < q0.size(); i++) begin
            tests++;
            if (q0[i] !== exp[i]) begin fails++; $display("FAIL latch_byte%0d got %02h want %02h", i, q0[i], exp[i]); end
        end
        tests += 3;
        if (a0.size() != 2) begin fails++; $display("FAIL latch_reads got %0d want 2", a0.size()); end
        else begin
            if (a0[0] !== 12'h100) begin fails++; $display("FAIL latch_addr0 got %03h want 100", a0[0]); end
            if (a0[1] !== 12'h101) begin fails++; $display("FAIL latch_addr1 got %03h want 101", a0[1]); end
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] exp [$];
        mem[12'h010] = 8'h11; mem[12'h011] = 8'h22; mem[12'h012] = 8'h33; mem[12'h013] = 8'h44;
        @(negedge clk);
        btype = T_DATA0; tx_dlen = 12'd4; ram_addr_init = 12'h010; fs = 1'b1;
        repeat (10) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        tests += 5;
        if (txv[0] !== 1'b0) begin fails++; $display("FAIL arst_txv got %b want 0", txv[0]); end
        if (txd[0] !== 8'h00) begin fails++; $display("FAIL arst_txd got %02h want 00", txd[0]); end
        if (bsy[0] !== 1'b0) begin fails++; $display("FAIL arst_busy got %b want 0", bsy[0]); end
        if (ren[0] !== 1'b0) begin fails++; $display("FAIL arst_ren got %b want 0", ren[0]); end
        if (rxa[0] !== 12'h000) begin fails++; $display("FAIL arst_rxa got %03h want 000", rxa[0]); end
        fs = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        exp = {8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h0F, 8'hA5};
        run_packet(4'hA, 12'd0, 12'h000, -1, -1);
        tests++;
        if (q0.size() != exp.size()) begin fails++; $display("FAIL arst_nak_len got %0d want %0d", q0.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < q0.size(); i++) begin
            tests++;
            if (q0[i] !== exp[i]) begin fails++; $display("FAIL arst_nak_byte%0d got %02h want %02h", i, q0[i], exp[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_data0();
        test_ack();
        test_zero_len();
        test_wrap();
        test_abort();
        test_illegal();
        test_latch();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/com_txp.md
Name: com_txp

Overview:
- Parametrised packet transmitter, next generation of the byte-serial link TX.
- Frames one packet per fs/fd handshake: preamble, sync, PID, optional 2-byte length, payload read from a synchronous RAM, CRC5 or CRC16, then inter-packet gap.
- Adds over the previous TX:
  - configurable RAM latency, preamble length, address width and gap length;
  - request latching at start;
  - a byte-valid strobe;
  - zero-length payloads;
  - abort;
  - illegal-type error.
- Sits between the packet scheduler (fs/btype/dlen) and the line serialiser (com_txd/com_txv).

Parameters:
- ADDR_W, 12, RAM address and length width (8..16).
- RAM_LAT, 2, read latency of ram_rxd after ram_rxa, in cycles (1..4).
- PLEN, 4, preamble byte count (1..15).
- GAP_LEN, 2, idle cycles after the last byte (1..15).

Ports:
- clk  in  1  clock.
- rst  in  1  reset. Asynchronous, active-low.
- fs  in  1  start request; level, held until fd.
- fd  out  1  packet done; high in DONE.
- abort  in  1  synchronous abort.
- btype  in  4  packet type; same codes as the link package.
- tx_dlen  in  ADDR_W  payload byte count.
- ram_addr_init  in  ADDR_W  payload base address.
- ram_rxa  out  ADDR_W  RAM read address.
- ram_ren  out  1  RAM read enable.
- ram_rxd  in  8  RAM read data.
- com_txd  out  8  line byte.
- com_txv  out  1  com_txd valid.
- busy  out  1  state not IDLE/WAIT/DONE.
- err  out  1  one-cycle pulse on illegal btype.

Behaviour:
- Reset values: com_txd=0x00, com_txv=0, fd=0, busy=0, err=0, ram_ren=0, ram_rxa=0, state IDLE.
- States: IDLE -> WAIT unconditionally.
- WAIT -> PREM on fs. In that same cycle, btype, tx_dlen and ram_addr_init are latched; later input changes are ignored.
- Illegal btype (not ACK/NAK/STL/DLINK/DTYPE/DTEMP/DATA0/DATA1): WAIT -> DONE, err pulses once, no bytes emitted.
- Emitted bytes, one per cycle:
  - PREM: 0x5A, PLEN cycles.
  - SYNC: 0x0F.
  - WPID: PID.
  - ACK/NAK/STL: WPID -> GAP.
  - Data types: DNUM emits {zero-padded dlen[ADDR_W-1:8]} then dlen[7:0].
  - DNUM -> WORK; if dlen==0, DNUM -> CRC directly.
  - WORK: dlen cycles, byte k = RAM[base+k].
  - CRC: CRC5 types emit 1 byte; DATA0/1 emit 2 bytes, high byte first.
  - GAP: GAP_LEN cycles, com_txv=0, com_txd=0x00.
  - DONE: held until fs low, then WAIT.
- PID encoding: ACK 0x2D, NAK 0xA5, STL 0xE1, DLINK/DTYPE/DTEMP 0xD2, DATA0 0x96, DATA1 0x5A.
- Output timing: com_txd/com_txv are registered; a byte produced in state cycle n appears at cycle n+1. com_txv=1 exactly for emitted bytes, gapless from first preamble byte to last CRC byte.
- CRC coverage: payload bytes only, using the existing crc5/crc16 units. The CRC register is cleared in WAIT. Empty payload emits the init CRC value.
- RAM reads:
  - ram_ren pulses exactly dlen times, for addresses base..base+dlen-1 in order.
  - First issue is RAM_LAT cycles before WORK's first cycle, so ram_rxd is aligned with WORK.
  - ram_rxa holds its last value otherwise.
  - PLEN+3 >= RAM_LAT is required; enforced by an elaboration-time check.
- Length arithmetic: dlen counter is ADDR_W wide; base+k wraps modulo 2^ADDR_W.
- abort high in any busy state: next state GAP, com_txv drops next cycle, ram_ren=0, fd follows as normal. Abort is ignored in IDLE/WAIT/DONE.
- fs dropping mid-packet has no effect.
- Async reset mid-packet returns immediately to reset values.

Optional Feature:
- COM_TXP_STAT_EN
  - Defined: adds outputs pkt_cnt[15:0] and abort_cnt[15:0]. They count packets reaching DONE without abort, and aborted packets. Both saturate at 0xFFFF and reset to 0.
  - Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared link package holds: btype codes, PID constants, preamble/sync bytes, and the state encoding.
- One natural sub-module: com_txp_rdgen, the RAM read-address/enable generator with the RAM_LAT lead.
- crc5/crc16 are instantiated unchanged.

Test Plan:
- DATA0, dlen=4, base=0x010, RAM=11 22 33 44, defaults -> com_txv run: 5A x4, 0F, 96, 00, 04, 11 22 33 44, then CRC16 high, low (model-checked). Then 2 idle cycles, then fd.
- ACK -> exactly 5A x4, 0F, 2D; no ram_ren; fd after gap.
- DLINK, dlen=0 -> ..., D2, 00, 00, one CRC5 byte equal to the init value; ram_ren never asserted.
- RAM_LAT=1 and 4 builds, DATA1 dlen=3 at base=0xFFE (ADDR_W=12) -> addresses FFE, FFF, 000; payload aligned.
- abort during the 2nd payload byte -> com_txv low next cycle, GAP then DONE; the next packet is transmitted correctly.
- btype=0x7 -> err one pulse, no com_txv, fd; tx_dlen changed mid-packet -> no effect.
